// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int unsigned MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner select between the CPU and DMA masters.
// ARB_ROUND_ROBIN_EN: ties go to the master not granted last;
// otherwise the CPU always wins ties.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic cpuReq,
  input  logic dmaReq,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic lastGrant,
`endif
  output logic grantValid,
  output logic grantOwner
);

  // Pick the owner of the next transaction from the pending requests.
  always_comb begin
    grantValid = cpuReq | dmaReq;
    grantOwner = OWN_CPU;
    if (cpuReq && dmaReq) begin
`ifdef ARB_ROUND_ROBIN_EN
      grantOwner = (lastGrant == OWN_DMA) ? OWN_CPU : OWN_DMA;
`else
      grantOwner = OWN_CPU;
`endif
    end else if (dmaReq) begin
      grantOwner = OWN_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and the DMA/loader.
// Optional build macro ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic              owner, ownerNext;
  logic              latWe, latWeNext;
  logic              memReadNext, memWriteNext;
  logic [ADDR_W-1:0] memAddrNext;
  logic [DATA_W-1:0] memWdataNext;
  logic [DATA_W-1:0] cpuRdataNext, dmaRdataNext;
  logic              cpuAckNext, dmaAckNext;
  logic              grantValid, grantOwner;
  logic              selWe;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrant, lastGrantNext;
`endif

  dmem_arb_pick uPick (
    .cpuReq     (cpu_req),
    .dmaReq     (dma_req),
`ifdef ARB_ROUND_ROBIN_EN
    .lastGrant  (lastGrant),
`endif
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;

  // Next-state and next-output logic; the memory port signals are computed
  // one cycle ahead so that every port output comes straight from a flop.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    ownerNext    = owner;
    latWeNext    = latWe;
    memReadNext  = 1'b0;
    memWriteNext = 1'b0;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    cpuRdataNext = cpu_rdata;
    dmaRdataNext = dma_rdata;
    cpuAckNext   = 1'b0;
    dmaAckNext   = 1'b0;
    selWe        = (grantOwner == OWN_DMA) ? dma_we : cpu_we;
`ifdef ARB_ROUND_ROBIN_EN
    lastGrantNext = lastGrant;
`endif
    case (state)
      IDLE: begin
        if (grantValid) begin
          ownerNext    = grantOwner;
          latWeNext    = selWe;
          memAddrNext  = (grantOwner == OWN_DMA) ? dma_addr  : cpu_addr;
          memWdataNext = (grantOwner == OWN_DMA) ? dma_wdata : cpu_wdata;
          memReadNext  = ~selWe;
          memWriteNext = selWe;
          cntNext      = CNT_W'(MEM_LAT - 1);
          stateNext    = ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
          lastGrantNext = grantOwner;
`endif
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          stateNext = RESP;
          if (owner == OWN_DMA) begin
            dmaAckNext = 1'b1;
            if (!latWe) dmaRdataNext = mem_rdata;
          end else begin
            cpuAckNext = 1'b1;
            if (!latWe) cpuRdataNext = mem_rdata;
          end
        end else begin
          // Read strobe stays up for the whole access; write strobe does not.
          cntNext     = cnt - 1'b1;
          memReadNext = ~latWe;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      owner <= OWN_CPU;
      latWe <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      owner <= ownerNext;
      latWe <= latWeNext;
    end
  end

  // Registered memory port, read data and acknowledges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      mem_read  <= memReadNext;
      mem_write <= memWriteNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      cpu_rdata <= cpuRdataNext;
      dma_rdata <= dmaRdataNext;
      cpu_ack   <= cpuAckNext;
      dma_ack   <= dmaAckNext;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant memory for round-robin tie breaking; first tie goes to CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lastGrant <= OWN_DMA;
    else        lastGrant <= lastGrantNext;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (MEM_LAT = 3).
module tb_dmem_arbiter;

  localparam int unsigned LAT = 3;
  localparam int TIMEOUT = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] dma_rdata;
  logic        dma_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data is a fixed scramble of the address.
  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  assign mem_rdata = memFn(mem_addr);

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cpuQ[$], dmaQ[$];
  int          nCmp = 0, nFail = 0;
  int          cycle = 0;
  int          rdCnt = 0, wrCnt = 0, stallCnt = 0;
  logic [31:0] cpuRdModel = '0, dmaRdModel = '0;
  int          ackOwner[$], ackCycle[$];

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1ns after each rising edge, pops the expected
  // transaction of whichever master is acknowledged.
  initial forever begin
    txn_t t;
    logic hit;
    @(posedge clk);
    #1;
    if (!reset) begin
      rdCnt = 0;
      wrCnt = 0;
    end else begin
      if (cpu_stall) stallCnt++;
      if (mem_read) rdCnt++;
      if (mem_write) begin
        wrCnt++;
        hit = 1'b0;
        if (cpuQ.size() > 0 && cpuQ[0].we && cpuQ[0].addr == mem_addr && cpuQ[0].wdata == mem_wdata) hit = 1'b1;
        if (dmaQ.size() > 0 && dmaQ[0].we && dmaQ[0].addr == mem_addr && dmaQ[0].wdata == mem_wdata) hit = 1'b1;
        chk("mem_write_match", hit, 1);
        chk("mem_read_during_write", mem_read, 0);
      end
      if (cpu_ack || dma_ack) begin
        chk("ack_exclusive", cpu_ack & dma_ack, 0);
        if (cpu_ack) begin
          if (cpuQ.size() == 0) chk("cpu_unexpected_ack", cpu_ack, 0);
          else begin
            t = cpuQ.pop_front();
            if (!t.we) cpuRdModel = memFn(t.addr);
            chk("cpu_rdata", cpu_rdata, cpuRdModel);
            chk("cpu_read_cycles", rdCnt, t.we ? 0 : LAT);
            chk("cpu_write_cycles", wrCnt, t.we ? 1 : 0);
          end
          chk("dma_rdata_hold", dma_rdata, dmaRdModel);
          ackOwner.push_back(0);
        end else begin
          if (dmaQ.size() == 0) chk("dma_unexpected_ack", dma_ack, 0);
          else begin
            t = dmaQ.pop_front();
            if (!t.we) dmaRdModel = memFn(t.addr);
            chk("dma_rdata", dma_rdata, dmaRdModel);
            chk("dma_read_cycles", rdCnt, t.we ? 0 : LAT);
            chk("dma_write_cycles", wrCnt, t.we ? 1 : 0);
          end
          chk("cpu_rdata_hold", cpu_rdata, cpuRdModel);
          ackOwner.push_back(1);
        end
        ackCycle.push_back(cycle);
        rdCnt = 0;
        wrCnt = 0;
      end
    end
  end

  // One master transaction: queue expectation, raise req, wait for ack.
  task automatic doTxn(input bit isDma, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    txn_t t;
    logic seen;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (isDma) begin
      dmaQ.push_back(t);
      dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
    end else begin
      cpuQ.push_back(t);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
      seen = isDma ? dma_ack : cpu_ack;
    end
    chk(isDma ? "dma_ack_before_timeout" : "cpu_ack_before_timeout", seen, 1);
    if (!seen) begin
      if (isDma) void'(dmaQ.pop_back());
      else       void'(cpuQ.pop_back());
    end
    if (isDma) dma_req = 1'b0;
    else       cpu_req = 1'b0;
  endtask

  task automatic randMaster(input bit isDma, input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      doTxn(isDma, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  int lat, lat2, startIdx;
  int expOwner[$];

  initial begin
    // Reset state
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_rdata", cpu_rdata | dma_rdata, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_outputs", {mem_read, mem_write, cpu_ack, dma_ack}, 0);

    // Solo CPU read at 0x10
    stallCnt = 0;
    doTxn(0, 1'b0, 32'h10, 32'h0, lat);
    chk("cpu_read_latency", lat, LAT + 1);
    chk("cpu_stall_cycles", stallCnt, LAT);
    chk("cpu_read_value", cpu_rdata, memFn(32'h10));
    @(negedge clk);

    // Solo DMA write
    doTxn(1, 1'b1, 32'h4000_000C, 32'h0000_00FF, lat);
    chk("dma_write_latency", lat, LAT + 1);
    chk("cpu_rdata_after_dma_write", cpu_rdata, memFn(32'h10));

    // Simultaneous reads held continuously
    startIdx = ackOwner.size();
`ifdef ARB_ROUND_ROBIN_EN
    expOwner = '{0, 1, 0, 1};
    fork
      begin doTxn(0, 1'b0, 32'h100, 0, lat); doTxn(0, 1'b0, 32'h104, 0, lat); end
      begin doTxn(1, 1'b0, 32'h200, 0, lat2); doTxn(1, 1'b0, 32'h204, 0, lat2); end
    join
`else
    expOwner = '{0, 0, 0, 0, 1};
    fork
      begin for (int i = 0; i < 4; i++) doTxn(0, 1'b0, 32'h100 + 32'(i * 4), 0, lat); end
      doTxn(1, 1'b0, 32'h200, 0, lat2);
    join
`endif
    chk("tie_phase_ack_count", ackOwner.size() - startIdx, expOwner.size());
    for (int i = 0; i < expOwner.size() && startIdx + i < ackOwner.size(); i++) begin
      chk("tie_grant_order", ackOwner[startIdx + i], expOwner[i]);
      if (i > 0) chk("tie_ack_spacing", ackCycle[startIdx + i] - ackCycle[startIdx + i - 1], LAT + 2);
    end

    // Random traffic from both masters
    repeat (2) @(negedge clk);
    fork
      randMaster(0, 30);
      randMaster(1, 30);
    join
    repeat (4) @(negedge clk);

    // Reset during the second access cycle of a DMA write
    chk("pre_reset_rdata_nonzero", (cpu_rdata != 0) && (dma_rdata != 0), 1);
    begin
      txn_t t;
      t.we = 1'b1; t.addr = 32'h4000_0010; t.wdata = 32'hCAFE_0001;
      dmaQ.push_back(t);
      dma_we = 1'b1; dma_addr = t.addr; dma_wdata = t.wdata; dma_req = 1'b1;
    end
    @(negedge clk);
    chk("abort_first_cycle_write", mem_write, 1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    dma_req = 1'b0;
    dmaQ.delete();
    cpuRdModel = '0;
    dmaRdModel = '0;
    chk("abort_mem_write", mem_write, 0);
    chk("abort_mem_read", mem_read, 0);
    chk("abort_dma_ack", dma_ack, 0);
    chk("abort_rdata", {cpu_rdata, dma_rdata} != 0, 0);
    chk("abort_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    startIdx = ackOwner.size();
    repeat (6) @(negedge clk);
    chk("no_ack_after_abort", ackOwner.size() - startIdx, 0);
    doTxn(0, 1'b0, 32'h20, 0, lat);
    chk("post_abort_cpu_latency", lat, LAT + 1);

    repeat (4) @(negedge clk);
    chk("cpuQ_drained", cpuQ.size(), 0);
    chk("dmaQ_drained", dmaQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port (DataMemory, including its tube MMIO window) between the CPU MEM stage and a second bus master (DMA / program loader). It serialises requests through a small FSM, drives the memory port for a configurable access latency, returns read data with a one-cycle acknowledge, and produces the MEM-stage stall the pipeline needs while the CPU waits.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles the memory port is driven per access (≥1)

- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  ADDR_W  byte address; stable while cpu_req
- cpu_wdata  in  DATA_W  write data; stable while cpu_req
- cpu_rdata  out  DATA_W  read data, valid in cpu_ack cycle, held after
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational), to HazardUnit
- dma_req, dma_we, dma_addr, dma_wdata  in  same widths and rules as CPU side
- dma_rdata  out  DATA_W  as cpu_rdata
- dma_ack  out  1  as cpu_ack
- mem_read  out  1  to DataMemory MemRead
- mem_write  out  1  to DataMemory MemWrite
- mem_addr  out  ADDR_W  to DataMemory Address
- mem_wdata  out  DATA_W  to DataMemory Write_data
- mem_rdata  in  DATA_W  from DataMemory Read_data

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, select winner, latch owner/we/addr/wdata, load cnt = MEM_LAT-1, go ACCESS. No req: stay.
- ACCESS: mem_addr/mem_wdata from latched values; mem_read = ~we for every ACCESS cycle; mem_write = we only in the first ACCESS cycle (single write per transaction, MMIO-safe). cnt decrements; at cnt==0, capture mem_rdata into owner's rdata register (reads only), go RESP.
- RESP: owner's ack = 1 for this cycle only; mem_read/mem_write = 0; go IDLE unconditionally. Requester drops or renews req after seeing ack; IDLE re-arbitrates next cycle.
- Arbitration without macro: CPU fixed priority.
- Non-owner rdata registers unchanged; writes leave rdata unchanged.
- Requests arriving during ACCESS/RESP wait; no request is dropped.

## Timing
- Reset (asserted low, any state): state IDLE, cnt 0, mem_read/mem_write 0, mem_addr/mem_wdata 0, both rdata 0, both ack 0, last-grant = DMA. Transaction in progress is abandoned; no write issued after reset asserts.
- req sampled in IDLE at edge T → ACCESS cycles T+1..T+MEM_LAT → ack in cycle T+MEM_LAT+1. Req→ack = MEM_LAT+1 cycles (2 at default).
- Back-to-back from same master: next req sampled in IDLE one cycle after ack; minimum period MEM_LAT+2 cycles.
- All outputs except cpu_stall are registered.
- Simultaneous cpu_req and dma_req in IDLE: winner per arbitration rule; loser granted in the immediately following IDLE.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie in IDLE goes to the master not granted last; last-grant register updates on each grant. First tie after reset goes to CPU.
- Undefined: CPU always wins ties; last-grant register removed; DMA can starve under continuous CPU traffic.

## Structure
- Package dmem_arb_pkg: state enum (IDLE/ACCESS/RESP), owner IDs (OWN_CPU = 0, OWN_DMA = 1), MEM_LAT default constant.
- One sub-module: dmem_arb_pick — combinational winner select from (cpu_req, dma_req, last_grant), fixed or round-robin per macro.

## Test plan
- Reset mid-ACCESS of a DMA write (MEM_LAT=3, reset low in second ACCESS cycle) → mem_write 0 from reset, state IDLE, dma_ack never pulses, rdata 0.
- CPU read addr 0x10, mem_rdata 0xDEADBEEF, MEM_LAT=1 → mem_read high 1 cycle, cpu_ack at cycle 2, cpu_rdata 0xDEADBEEF, cpu_stall high cycles 0–1.
- DMA write 0x4000000C/0x000000FF, MEM_LAT=3 → mem_write exactly 1 cycle, mem_read 0, dma_ack at cycle 4, cpu_rdata unchanged.
- Simultaneous CPU and DMA reads, repeated 4×, ARB_ROUND_ROBIN_EN set → grants alternate CPU, DMA, CPU, DMA; each ack 2 cycles after its grant.
- Same stimulus, macro undefined, CPU req held continuously → every grant CPU, dma_ack never asserts, cpu_ack every 3 cycles.
